// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_EXEC_R    = 5'd3,
        S_EXEC_I    = 5'd4,
        S_WB_ALU    = 5'd5,
        S_BRANCH    = 5'd6,
        S_MEM_ADDR  = 5'd7,
        S_LOAD_MEM  = 5'd8,
        S_LOAD_WB   = 5'd9,
        S_STORE_MEM = 5'd10,
        S_LUI_WB    = 5'd11,
        S_JAL       = 5'd12,
        S_JALR      = 5'd13,
        S_TRAP      = 5'd14
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    // Which instruction class the funct decoder is interpreting.
    typedef enum logic [1:0] {
        DEC_R = 2'd0,
        DEC_I = 2'd1,
        DEC_B = 2'd2
    } dec_mode_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_IMM    = 2'd2;
    localparam logic [1:0] WB_PC     = 2'd3;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_REG  = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Debug code shown instead of S_TRAP when the flush variant is built.
    localparam logic [4:0] DBG_FLUSH = 5'h1F;

endpackage

// File: rtl/mc_alu_dec.sv
// Translates funct3/funct7 into an ALU operation and flags encodings we do not support.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  dec_mode_e  mode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    alu_op_o,
    output logic       illegal_o
);

    logic funct7Zero;
    logic funct7Alt;

    assign funct7Zero = (funct7_i == 7'b0000000);
    assign funct7Alt  = (funct7_i == 7'b0100000);

    // I-type immediates reuse the funct7 bits, so only shifts look at them there.
    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        if (mode_i == DEC_B) begin
            case (funct3_i)
                3'b000, 3'b001: alu_op_o = ALU_SUB;
                3'b100, 3'b101: alu_op_o = ALU_SLT;
                3'b110, 3'b111: alu_op_o = ALU_SLTU;
                default:        illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                3'b000:  alu_op_o = (mode_i == DEC_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op_o = ALU_SLL;
                3'b010:  alu_op_o = ALU_SLT;
                3'b011:  alu_op_o = ALU_SLTU;
                3'b100:  alu_op_o = ALU_XOR;
                3'b101:  alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op_o = ALU_OR;
                default: alu_op_o = ALU_AND;
            endcase
            if (mode_i == DEC_R) begin
                illegal_o = !(funct7Zero ||
                              (funct7Alt && (funct3_i == 3'b000 || funct3_i == 3'b101)));
            end else begin
                illegal_o = (funct3_i == 3'b001 && !funct7Zero) ||
                            (funct3_i == 3'b101 && !(funct7Zero || funct7Alt));
            end
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32 controller: sequences datapath enables, selects and memory handshakes.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter int ENABLE_JUMPS  = 1,
    parameter int FLUSH_ON_TRAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ack,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_load,
    output logic        reg_a_load,
    output logic        reg_b_load,
    output logic        alu_out_load,
    output logic        mdr_load,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [1:0]  mem_size,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [4:0]  state_dbg
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic       JUMPS_ON    = (ENABLE_JUMPS != 0);
    localparam logic       FLUSH_DBG   = (FLUSH_ON_TRAP != 0);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [7:0] waitInc;
    logic       timeoutHit;
    logic       branchTaken;
    dec_mode_e  decMode;
    alu_op_e    decAluOp;
    logic       decIllegal;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign waitInc    = wait_q + 8'd1;
    assign timeoutHit = (waitInc == TIMEOUT_CNT);
    assign trap       = trap_q;
    assign state_dbg  = (FLUSH_DBG && state_q == S_TRAP) ? DBG_FLUSH : state_q;

    mc_alu_dec u_alu_dec (
        .mode_i    (decMode),
        .funct3_i  (funct3),
        .funct7_i  (instr[31:25]),
        .alu_op_o  (decAluOp),
        .illegal_o (decIllegal)
    );

    // Tell the funct decoder which instruction class the current state is executing.
    always_comb begin
        decMode = DEC_R;
        if (state_q == S_EXEC_I) decMode = DEC_I;
        else if (state_q == S_BRANCH) decMode = DEC_B;
    end

    // Branch condition from the ALU flags; the ALU was set up to compare rs1 with rs2.
    always_comb begin
        branchTaken = 1'b0;
        case (funct3)
            3'b000:         branchTaken = alu_zero;
            3'b001:         branchTaken = !alu_zero;
            3'b100, 3'b110: branchTaken = alu_lt;
            3'b101, 3'b111: branchTaken = !alu_lt;
            default:        branchTaken = 1'b0;
        endcase
    end

    // State register, memory wait counter and sticky trap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_q | (state_d == S_TRAP);
        end
    end

    // Next state and datapath controls; the wait counter only survives while a state waits on memory.
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        ir_load      = 1'b0;
        reg_a_load   = 1'b0;
        reg_b_load   = 1'b0;
        alu_out_load = 1'b0;
        mdr_load     = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_REG;
        alu_op       = ALU_ADD;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        mem_size     = SIZE_BYTE;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_size  = SIZE_WORD;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_ALU;
                    state_d  = S_DECODE;
                end else if (timeoutHit) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = waitInc;
                end
            end
            S_DECODE: begin
                reg_a_load   = 1'b1;
                reg_b_load   = 1'b1;
                alu_out_load = 1'b1;
                alu_src_b    = SRC_B_IMM;
                if (instr == 32'h0) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:              state_d = S_EXEC_R;
                        OP_IMM:            state_d = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_LUI:            state_d = S_LUI_WB;
                        OP_JAL:            state_d = JUMPS_ON ? S_JAL : S_TRAP;
                        OP_JALR:           state_d = JUMPS_ON ? S_JALR : S_TRAP;
                        default:           state_d = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = (state_q == S_EXEC_R) ? SRC_B_REG : SRC_B_IMM;
                alu_op       = decAluOp;
                alu_out_load = 1'b1;
                state_d      = (state_q == S_EXEC_R && decIllegal) ? S_TRAP : S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                wb_sel    = WB_ALUOUT;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = decAluOp;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = branchTaken && !decIllegal;
                state_d   = decIllegal ? S_TRAP : S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a    = SRC_A_REG;
                alu_src_b    = SRC_B_IMM;
                alu_out_load = 1'b1;
                state_d      = (opcode == OP_LOAD) ? S_LOAD_MEM : S_STORE_MEM;
            end
            S_LOAD_MEM, S_STORE_MEM: begin
                mem_req      = 1'b1;
                mem_we       = (state_q == S_STORE_MEM);
                mem_addr_sel = 1'b1;
                mem_size     = funct3[1:0];
                if (mem_ack) begin
                    mdr_load = (state_q == S_LOAD_MEM);
                    state_d  = (state_q == S_LOAD_MEM) ? S_LOAD_WB : S_FETCH;
                end else if (timeoutHit) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = waitInc;
                end
            end
            S_LOAD_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
                state_d   = S_FETCH;
            end
            S_LUI_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_IMM;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_ALUOUT;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_JALR;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; a second instance is built with jumps disabled.
module tb_mc_control_unit;

    localparam int ST_RESET  = 0;
    localparam int ST_FETCH  = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_EXEC_R = 3;
    localparam int ST_EXEC_I = 4;
    localparam int ST_WB_ALU = 5;
    localparam int ST_BRANCH = 6;
    localparam int ST_MADDR  = 7;
    localparam int ST_LOAD   = 8;
    localparam int ST_LWB    = 9;
    localparam int ST_STORE  = 10;
    localparam int ST_LUI    = 11;
    localparam int ST_JALR   = 13;
    localparam int ST_TRAP   = 14;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SRAI  = 32'h4030D093;
    localparam logic [31:0] I_ADDI  = 32'h40000093;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_SB    = 32'h00208023;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_BNE   = 32'h00209063;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BLTU  = 32'h0020E063;
    localparam logic [31:0] I_BR010 = 32'h0020A063;
    localparam logic [31:0] I_JALR  = 32'h000100E7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        alu_zero, alu_lt, mem_ack;

    logic       pc_write, ir_load, reg_a_load, reg_b_load, alu_out_load, mdr_load;
    logic       mem_req, mem_we, mem_addr_sel, reg_write, trap;
    logic [1:0] pc_src, alu_src_a, alu_src_b, mem_size, wb_sel;
    logic [3:0] alu_op;
    logic [4:0] state_dbg;

    logic       njPcWrite, njIrLoad, njRegALoad, njRegBLoad, njAluOutLoad, njMdrLoad;
    logic       njMemReq, njMemWe, njMemAddrSel, njRegWrite, njTrap;
    logic [1:0] njPcSrc, njAluSrcA, njAluSrcB, njMemSize, njWbSel;
    logic [3:0] njAluOp;
    logic [4:0] njStateDbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ack(mem_ack), .pc_write(pc_write), .pc_src(pc_src), .ir_load(ir_load),
        .reg_a_load(reg_a_load), .reg_b_load(reg_b_load), .alu_out_load(alu_out_load),
        .mdr_load(mdr_load), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .mem_size(mem_size),
        .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap), .state_dbg(state_dbg)
    );

    mc_control_unit #(.ENABLE_JUMPS(0)) dutNoJump (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ack(mem_ack), .pc_write(njPcWrite), .pc_src(njPcSrc), .ir_load(njIrLoad),
        .reg_a_load(njRegALoad), .reg_b_load(njRegBLoad), .alu_out_load(njAluOutLoad),
        .mdr_load(njMdrLoad), .alu_src_a(njAluSrcA), .alu_src_b(njAluSrcB), .alu_op(njAluOp),
        .mem_req(njMemReq), .mem_we(njMemWe), .mem_addr_sel(njMemAddrSel), .mem_size(njMemSize),
        .reg_write(njRegWrite), .wb_sel(njWbSel), .trap(njTrap), .state_dbg(njStateDbg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic ack,
                                 input logic zero, input logic lt);
        instr    = ins;
        mem_ack  = ack;
        alu_zero = zero;
        alu_lt   = lt;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack at once, pass DECODE, land in the dispatched state with ack low.
    task automatic fetchDecode(input logic [31:0] ins);
        applyStimulus(ins, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(ins, 1'b0, 1'b0, 1'b0);
        nextCycle();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("rst_state", 32'(state_dbg), ST_RESET);
        checkOutput("rst_memreq", 32'(mem_req), 0);
        checkOutput("rst_trap", 32'(trap), 0);
        checkOutput("rst_regwr", 32'(reg_write), 0);
        checkOutput("rst_pcwr", 32'(pc_write), 0);
        rst = 1'b0;
        nextCycle();

        // add x3,x1,x2
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("add_f_state", 32'(state_dbg), ST_FETCH);
        checkOutput("add_f_memreq", 32'(mem_req), 1);
        checkOutput("add_f_irload", 32'(ir_load), 1);
        checkOutput("add_f_pcwr", 32'(pc_write), 1);
        checkOutput("add_f_size", 32'(mem_size), 2);
        checkOutput("add_f_srcb", 32'(alu_src_b), 1);
        checkOutput("add_f_regwr", 32'(reg_write), 0);
        nextCycle();
        applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
        checkOutput("add_d_state", 32'(state_dbg), ST_DECODE);
        checkOutput("add_d_rega", 32'(reg_a_load), 1);
        checkOutput("add_d_regb", 32'(reg_b_load), 1);
        checkOutput("add_d_aluout", 32'(alu_out_load), 1);
        checkOutput("add_d_srcb", 32'(alu_src_b), 2);
        checkOutput("add_d_memreq", 32'(mem_req), 0);
        checkOutput("add_d_regwr", 32'(reg_write), 0);
        nextCycle();
        checkOutput("add_e_state", 32'(state_dbg), ST_EXEC_R);
        checkOutput("add_e_srca", 32'(alu_src_a), 1);
        checkOutput("add_e_srcb", 32'(alu_src_b), 0);
        checkOutput("add_e_aluop", 32'(alu_op), 0);
        checkOutput("add_e_regwr", 32'(reg_write), 0);
        nextCycle();
        checkOutput("add_w_state", 32'(state_dbg), ST_WB_ALU);
        checkOutput("add_w_regwr", 32'(reg_write), 1);
        checkOutput("add_w_wbsel", 32'(wb_sel), 0);
        nextCycle();
        checkOutput("add_back_fetch", 32'(state_dbg), ST_FETCH);

        // srai: funct7[5] selects arithmetic shift
        fetchDecode(I_SRAI);
        checkOutput("srai_state", 32'(state_dbg), ST_EXEC_I);
        checkOutput("srai_srcb", 32'(alu_src_b), 2);
        checkOutput("srai_aluop", 32'(alu_op), 9);
        nextCycle();
        nextCycle();

        // addi with immediate bit 10 set must stay ADD
        fetchDecode(I_ADDI);
        checkOutput("addi_state", 32'(state_dbg), ST_EXEC_I);
        checkOutput("addi_aluop", 32'(alu_op), 0);
        nextCycle();
        nextCycle();

        // lw with three wait cycles in FETCH and LOAD_MEM
        for (int k = 0; k < 3; k++) begin
            applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
            checkOutput("lw_f_wait_req", 32'(mem_req), 1);
            checkOutput("lw_f_wait_ir", 32'(ir_load), 0);
            nextCycle();
        end
        applyStimulus(I_LW, 1'b1, 1'b0, 1'b0);
        checkOutput("lw_f_ack_req", 32'(mem_req), 1);
        checkOutput("lw_f_ack_ir", 32'(ir_load), 1);
        nextCycle();
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
        checkOutput("lw_d_state", 32'(state_dbg), ST_DECODE);
        nextCycle();
        checkOutput("lw_a_state", 32'(state_dbg), ST_MADDR);
        checkOutput("lw_a_aluout", 32'(alu_out_load), 1);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            checkOutput("lw_m_state", 32'(state_dbg), ST_LOAD);
            checkOutput("lw_m_req", 32'(mem_req), 1);
            checkOutput("lw_m_addrsel", 32'(mem_addr_sel), 1);
            checkOutput("lw_m_size", 32'(mem_size), 2);
            checkOutput("lw_m_mdr_wait", 32'(mdr_load), 0);
            nextCycle();
        end
        applyStimulus(I_LW, 1'b1, 1'b0, 1'b0);
        checkOutput("lw_m_ack_req", 32'(mem_req), 1);
        checkOutput("lw_m_mdr_ack", 32'(mdr_load), 1);
        nextCycle();
        applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
        checkOutput("lw_wb_state", 32'(state_dbg), ST_LWB);
        checkOutput("lw_wb_regwr", 32'(reg_write), 1);
        checkOutput("lw_wb_wbsel", 32'(wb_sel), 1);
        checkOutput("lw_wb_mdr", 32'(mdr_load), 0);
        checkOutput("lw_wb_req", 32'(mem_req), 0);
        nextCycle();
        checkOutput("lw_back_fetch", 32'(state_dbg), ST_FETCH);

        // sb: byte-sized store acked immediately
        fetchDecode(I_SB);
        checkOutput("sb_a_state", 32'(state_dbg), ST_MADDR);
        nextCycle();
        applyStimulus(I_SB, 1'b1, 1'b0, 1'b0);
        checkOutput("sb_state", 32'(state_dbg), ST_STORE);
        checkOutput("sb_we", 32'(mem_we), 1);
        checkOutput("sb_size", 32'(mem_size), 0);
        checkOutput("sb_req", 32'(mem_req), 1);
        nextCycle();
        applyStimulus(I_SB, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_back_fetch", 32'(state_dbg), ST_FETCH);

        // lui
        fetchDecode(I_LUI);
        checkOutput("lui_state", 32'(state_dbg), ST_LUI);
        checkOutput("lui_regwr", 32'(reg_write), 1);
        checkOutput("lui_wbsel", 32'(wb_sel), 2);
        nextCycle();

        // bne with zero=0 is taken
        fetchDecode(I_BNE);
        applyStimulus(I_BNE, 1'b0, 1'b0, 1'b0);
        checkOutput("bne_state", 32'(state_dbg), ST_BRANCH);
        checkOutput("bne_aluop", 32'(alu_op), 1);
        checkOutput("bne_pcwr", 32'(pc_write), 1);
        checkOutput("bne_pcsrc", 32'(pc_src), 1);
        nextCycle();

        // beq with zero=0 is not taken, with zero=1 it is
        fetchDecode(I_BEQ);
        applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0);
        checkOutput("beq_aluop", 32'(alu_op), 1);
        checkOutput("beq_nz_pcwr", 32'(pc_write), 0);
        applyStimulus(I_BEQ, 1'b0, 1'b1, 1'b0);
        checkOutput("beq_z_pcwr", 32'(pc_write), 1);
        nextCycle();

        // bltu with lt=1 is taken
        fetchDecode(I_BLTU);
        applyStimulus(I_BLTU, 1'b0, 1'b0, 1'b1);
        checkOutput("bltu_aluop", 32'(alu_op), 3);
        checkOutput("bltu_pcwr", 32'(pc_write), 1);
        nextCycle();

        // jalr: legal with jumps enabled, traps on the jumps-disabled instance
        fetchDecode(I_JALR);
        checkOutput("jalr_state", 32'(state_dbg), ST_JALR);
        checkOutput("jalr_regwr", 32'(reg_write), 1);
        checkOutput("jalr_wbsel", 32'(wb_sel), 3);
        checkOutput("jalr_pcsrc", 32'(pc_src), 2);
        checkOutput("jalr_pcwr", 32'(pc_write), 1);
        checkOutput("jalr_srca", 32'(alu_src_a), 1);
        checkOutput("jalr_srcb", 32'(alu_src_b), 2);
        checkOutput("nojump_state", 32'(njStateDbg), ST_TRAP);
        checkOutput("nojump_trap", 32'(njTrap), 1);
        checkOutput("nojump_regwr", 32'(njRegWrite), 0);
        nextCycle();
        checkOutput("jalr_back_fetch", 32'(state_dbg), ST_FETCH);
        checkOutput("jalr_no_trap", 32'(trap), 0);

        // branch with funct3=010 traps and stays trapped
        fetchDecode(I_BR010);
        applyStimulus(I_BR010, 1'b0, 1'b1, 1'b1);
        checkOutput("br010_state", 32'(state_dbg), ST_BRANCH);
        checkOutput("br010_pcwr", 32'(pc_write), 0);
        checkOutput("br010_pretrap", 32'(trap), 0);
        nextCycle();
        checkOutput("br010_trapstate", 32'(state_dbg), ST_TRAP);
        checkOutput("br010_trap", 32'(trap), 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h0, 1'b1, 1'b1, 1'b1);
            nextCycle();
            checkOutput("trap_hold_state", 32'(state_dbg), ST_TRAP);
            checkOutput("trap_hold_trap", 32'(trap), 1);
            checkOutput("trap_hold_req", 32'(mem_req), 0);
            checkOutput("trap_hold_pcwr", 32'(pc_write), 0);
        end

        // reset clears trap on both instances
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        nextCycle();
        checkOutput("rst2_state", 32'(state_dbg), ST_RESET);
        checkOutput("rst2_trap", 32'(trap), 0);
        rst = 1'b0;
        nextCycle();
        checkOutput("rst2_fetch", 32'(state_dbg), ST_FETCH);
        checkOutput("rst2_nj_fetch", 32'(njStateDbg), ST_FETCH);
        checkOutput("rst2_nj_trap", 32'(njTrap), 0);

        // no ack in FETCH: 16 waiting cycles, then TRAP
        for (int k = 0; k < 16; k++) begin
            checkOutput("to_wait_state", 32'(state_dbg), ST_FETCH);
            checkOutput("to_wait_trap", 32'(trap), 0);
            nextCycle();
        end
        checkOutput("to_state", 32'(state_dbg), ST_TRAP);
        checkOutput("to_trap", 32'(trap), 1);
        checkOutput("to_req", 32'(mem_req), 0);

        // reset while a fetch request is pending drops mem_req next cycle
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("midrst_req_before", 32'(mem_req), 1);
        rst = 1'b1;
        nextCycle();
        checkOutput("midrst_req_after", 32'(mem_req), 0);
        checkOutput("midrst_state", 32'(state_dbg), ST_RESET);
        rst = 1'b0;
        nextCycle();
        checkOutput("midrst_fetch", 32'(state_dbg), ST_FETCH);
        checkOutput("midrst_trap", 32'(trap), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
